// File: rtl/pc8001_bus_pkg.sv
// Shared PC-8001 bus definitions: arbiter state encoding,
// default RAM address width and CRTC row length.
package pc8001_bus_pkg;

    localparam int unsigned ADR_W_DEFAULT = 17;

    // Bytes fetched by the CRTC for one character row.
    localparam logic [7:0] CRTC_ROW_LEN = 8'h78;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_REQ   = 2'd1,
        ARB_GRANT = 2'd2,
        ARB_GAP   = 2'd3
    } arb_state_e;

    // Counter width able to hold 0..max, never narrower than 1 bit.
    function automatic int unsigned cnt_w(input int unsigned max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/crtc_dma_arbiter_if.sv
// CRTC row-buffer DMA handshake bundle.
// The CRTC is the master, the arbiter is the slave.
interface crtc_dma_arbiter_if
    import pc8001_bus_pkg::*;
#(
    parameter int unsigned ADR_W = ADR_W_DEFAULT
) ();

    logic             dma_req;
    logic             dma_ack;
    logic [ADR_W-1:0] dma_adr;
    logic [7:0]       dma_data;

    modport master (
        output dma_req,
        output dma_adr,
        input  dma_ack,
        input  dma_data
    );

    modport slave (
        input  dma_req,
        input  dma_adr,
        output dma_ack,
        output dma_data
    );

endinterface

// File: rtl/crtc_dma_arbiter_bus_mux.sv
// CPU/DMA work-RAM mux. The select comes straight from the
// arbiter state flop, so the mux only switches on a clock edge.
module bus_mux
    import pc8001_bus_pkg::*;
#(
    parameter int unsigned ADR_W = ADR_W_DEFAULT
) (
    input  logic             dma_sel,
    input  logic [ADR_W-1:0] dma_adr,
    input  logic [ADR_W-1:0] cpu_adr,
    input  logic             cpu_wr,
    input  logic [7:0]       cpu_dout,
    input  logic [7:0]       mem_rdata,
    output logic [ADR_W-1:0] mem_adr,
    output logic             mem_we,
    output logic [7:0]       mem_wdata,
    output logic [7:0]       cpu_din,
    output logic [7:0]       dma_data
);

    // DMA owns the address and write is blocked while selected
    always_comb begin
        mem_adr   = cpu_adr;
        mem_we    = cpu_wr;
        mem_wdata = cpu_dout;
        if (dma_sel) begin
            mem_adr = dma_adr;
            mem_we  = 1'b0;
        end
    end

    // Read data fans out to both sides; each side knows when it is valid
    always_comb begin
        cpu_din  = mem_rdata;
        dma_data = mem_rdata;
    end

endmodule

// File: rtl/crtc_dma_arbiter.sv
// CRTC DMA arbiter: takes the Z80 bus via BUSRQ/BUSAK for the CRTC.
// Optional per-frame GRANT cycle statistics: define DMA_STAT_EN.
module crtc_dma_arbiter
    import pc8001_bus_pkg::*;
#(
    parameter int unsigned MIN_GAP = 4,
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned ADR_W   = ADR_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    crtc_dma_arbiter_if.slave dma,
    output logic             cpu_busrq_n,
    input  logic             cpu_busak_n,
    input  logic [ADR_W-1:0] cpu_adr,
    input  logic             cpu_wr,
    input  logic [7:0]       cpu_dout,
    output logic [7:0]       cpu_din,
    output logic [ADR_W-1:0] mem_adr,
    output logic             mem_we,
    output logic [7:0]       mem_wdata,
    input  logic [7:0]       mem_rdata,
    output logic             err_timeout,
    input  logic             clr_err
`ifdef DMA_STAT_EN
    ,
    input  logic             frame_strobe,
    output logic [15:0]      dma_cycles
`endif
);

    localparam logic [1:0] S_IDLE  = 2'(ARB_IDLE);
    localparam logic [1:0] S_REQ   = 2'(ARB_REQ);
    localparam logic [1:0] S_GRANT = 2'(ARB_GRANT);
    localparam logic [1:0] S_GAP   = 2'(ARB_GAP);

    localparam int unsigned WAIT_W = cnt_w(TIMEOUT);
    localparam int unsigned GAP_W  = cnt_w(MIN_GAP);

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
    localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);

    logic [1:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              err_q, err_d;
    logic              grant;
    logic              gap_last;
    logic              wait_sat;

    assign grant    = (state_q == S_GRANT);
    assign wait_sat = (wait_q == WAIT_MAX);

    // GAP lasts MIN_GAP cycles, but always at least one
    assign gap_last = ((32'(gap_q) + 32'd1) >= 32'(MIN_GAP));

    // Next-state, wait/gap counters and sticky timeout flag
    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        gap_d   = '0;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (dma.dma_req) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                wait_d = wait_sat ? wait_q : wait_q + WAIT_ONE;
                if (!cpu_busak_n) begin
                    state_d = S_GRANT;
                end else if (!dma.dma_req) begin
                    state_d = S_IDLE;
                end
            end
            S_GRANT: begin
                if (!dma.dma_req) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_last) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GAP_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (clr_err) begin
            err_d = 1'b0;
        end
        if ((state_q == S_REQ) && wait_sat) begin
            err_d = 1'b1;
        end
    end

    // Arbiter state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            gap_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            gap_q   <= gap_d;
            err_q   <= err_d;
        end
    end

    // Handshake outputs decode the state flop, so reset releases them at once
    always_comb begin
        cpu_busrq_n = !((state_q == S_REQ) || grant);
        dma.dma_ack = grant;
        err_timeout = err_q;
    end

    bus_mux #(
        .ADR_W (ADR_W)
    ) u_bus_mux (
        .dma_sel   (grant),
        .dma_adr   (dma.dma_adr),
        .cpu_adr   (cpu_adr),
        .cpu_wr    (cpu_wr),
        .cpu_dout  (cpu_dout),
        .mem_rdata (mem_rdata),
        .mem_adr   (mem_adr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .cpu_din   (cpu_din),
        .dma_data  (dma.dma_data)
    );

`ifdef DMA_STAT_EN
    logic        strobe_q, strobe_d;
    logic [15:0] run_q, run_d;
    logic [15:0] cyc_q, cyc_d;
    logic        frame_rise;

    assign frame_rise = frame_strobe && !strobe_q;

    // Count GRANT cycles; latch and restart on each vsync rise
    always_comb begin
        strobe_d = frame_strobe;
        run_d    = run_q;
        cyc_d    = cyc_q;
        if (grant && (run_q != 16'hFFFF)) begin
            run_d = run_q + 16'd1;
        end
        if (frame_rise) begin
            cyc_d = run_q;
            run_d = grant ? 16'd1 : 16'd0;
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_q <= 1'b0;
            run_q    <= '0;
            cyc_q    <= '0;
        end else begin
            strobe_q <= strobe_d;
            run_q    <= run_d;
            cyc_q    <= cyc_d;
        end
    end

    assign dma_cycles = cyc_q;
`else
    // Statistics disabled: no frame counter hardware.
`endif

endmodule

// File: tb/tb_crtc_dma_arbiter.sv
// Bench for crtc_dma_arbiter: directed handshake steps followed by
// randomized grant traffic against a RAM shadow model.
module tb_crtc_dma_arbiter;
    import pc8001_bus_pkg::*;

    localparam int unsigned AW   = 17;
    localparam int unsigned GAP  = 4;
    localparam int unsigned TOUT = 15;

    logic          clk;
    logic          rst_n;
    logic          cpu_busrq_n;
    logic          cpu_busak_n;
    logic [AW-1:0] cpu_adr;
    logic          cpu_wr;
    logic [7:0]    cpu_dout;
    logic [7:0]    cpu_din;
    logic [AW-1:0] mem_adr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic          err_timeout;
    logic          clr_err;
`ifdef DMA_STAT_EN
    logic          frame_strobe;
    logic [15:0]   dma_cycles;
`endif

    int checks;
    int errors;

    logic [7:0] seed_b;

    logic [7:0] ram   [0:(1<<AW)-1];
    bit         ram_v [0:(1<<AW)-1];
    logic [7:0] sh    [0:(1<<AW)-1];
    bit         sh_v  [0:(1<<AW)-1];

    crtc_dma_arbiter_if #(.ADR_W(AW)) dif ();

    crtc_dma_arbiter #(
        .MIN_GAP (GAP),
        .TIMEOUT (TOUT),
        .ADR_W   (AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dma          (dif),
        .cpu_busrq_n  (cpu_busrq_n),
        .cpu_busak_n  (cpu_busak_n),
        .cpu_adr      (cpu_adr),
        .cpu_wr       (cpu_wr),
        .cpu_dout     (cpu_dout),
        .cpu_din      (cpu_din),
        .mem_adr      (mem_adr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .err_timeout  (err_timeout),
        .clr_err      (clr_err)
`ifdef DMA_STAT_EN
        ,
        .frame_strobe (frame_strobe),
        .dma_cycles   (dma_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Power-up RAM contents are a fixed scramble of the address.
    function automatic logic [7:0] init_byte(input logic [AW-1:0] a);
        return a[7:0] ^ {a[16:15], a[13:8]} ^ seed_b;
    endfunction

    function automatic logic [7:0] exp_byte(input logic [AW-1:0] a);
        return sh_v[a] ? sh[a] : init_byte(a);
    endfunction

    // Synchronous RAM, one cycle read latency, read-before-write
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_adr]   <= mem_wdata;
            ram_v[mem_adr] <= 1'b1;
        end
        mem_rdata <= ram_v[mem_adr] ? ram[mem_adr] : init_byte(mem_adr);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sh_write(input logic [AW-1:0] a, input logic [7:0] d);
        sh[a]   = d;
        sh_v[a] = 1'b1;
    endtask

    // One complete DMA grant holding GRANT for n cycles.
    task automatic do_grant(input int n);
        dif.dma_req = 1'b1;
        tick();
        cpu_busak_n = 1'b0;
        tick();
        repeat (n - 1) tick();
        dif.dma_req = 1'b0;
        cpu_busak_n = 1'b1;
        tick();
        repeat (GAP) tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        logic [7:0]    v;
        int            w;
        int            len;
        bit            wr;

        checks       = 0;
        errors       = 0;
        seed_b       = 8'($urandom);
        rst_n        = 1'b0;
        dif.dma_req  = 1'b1;
        dif.dma_adr  = '0;
        cpu_busak_n  = 1'b1;
        cpu_adr      = 17'h00ABC;
        cpu_wr       = 1'b0;
        cpu_dout     = 8'h00;
        clr_err      = 1'b0;
`ifdef DMA_STAT_EN
        frame_strobe = 1'b0;
`endif

        // Reset held with a pending request
        repeat (3) tick();
        chk("rst_busrq_n", 32'(cpu_busrq_n), 32'd1);
        chk("rst_ack", 32'(dif.dma_ack), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        chk("rst_mux_adr", 32'(mem_adr), 32'h00ABC);
        rst_n = 1'b1;
        tick();
        chk("req_busrq_n", 32'(cpu_busrq_n), 32'd0);
        chk("req_ack", 32'(dif.dma_ack), 32'd0);

        // Normal grant after BUSAK delay, full CRTC row read
        repeat (4) begin
            tick();
            chk("wait_ack", 32'(dif.dma_ack), 32'd0);
        end
        cpu_busak_n = 1'b0;
        tick();
        chk("grant_ack", 32'(dif.dma_ack), 32'd1);
        chk("grant_busrq_n", 32'(cpu_busrq_n), 32'd0);
        for (int i = 0; i < int'(CRTC_ROW_LEN); i++) begin
            a           = 17'(17'h0F300 + i);
            dif.dma_adr = a;
            cpu_adr     = 17'($urandom);
            #1;
            chk("row_adr", 32'(mem_adr), 32'(a));
            tick();
            chk("row_data", 32'(dif.dma_data), 32'(exp_byte(a)));
        end
        dif.dma_req = 1'b0;
        tick();
        chk("drop_ack", 32'(dif.dma_ack), 32'd0);
        chk("drop_busrq_n", 32'(cpu_busrq_n), 32'd1);
        chk("gap_mux_adr", 32'(mem_adr), 32'(cpu_adr));
        cpu_busak_n = 1'b1;
        dif.dma_req = 1'b1;
        repeat (GAP) begin
            tick();
            chk("gap_busrq_n", 32'(cpu_busrq_n), 32'd1);
        end
        tick();
        chk("gap_rereq", 32'(cpu_busrq_n), 32'd0);

        // Abort: short request without BUSAK
        dif.dma_req = 1'b0;
        tick();
        chk("abort0_busrq_n", 32'(cpu_busrq_n), 32'd1);
        tick();
        dif.dma_req = 1'b1;
        tick();
        chk("abort_req", 32'(cpu_busrq_n), 32'd0);
        tick();
        chk("abort_ack1", 32'(dif.dma_ack), 32'd0);
        dif.dma_req = 1'b0;
        tick();
        chk("abort_busrq_n", 32'(cpu_busrq_n), 32'd1);
        chk("abort_ack2", 32'(dif.dma_ack), 32'd0);
        tick();
        chk("abort_idle", 32'(cpu_busrq_n), 32'd1);

        // Asynchronous reset in the middle of a grant
        dif.dma_req = 1'b1;
        tick();
        cpu_busak_n = 1'b0;
        tick();
        chk("mid_ack", 32'(dif.dma_ack), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_ack", 32'(dif.dma_ack), 32'd0);
        chk("async_busrq_n", 32'(cpu_busrq_n), 32'd1);
        tick();
        dif.dma_req = 1'b0;
        cpu_busak_n = 1'b1;
        rst_n       = 1'b1;
        tick();
        chk("post_rst_busrq_n", 32'(cpu_busrq_n), 32'd1);

        // Timeout: BUSAK withheld, clear collides with set
        dif.dma_req = 1'b1;
        tick();
        for (int k = 1; k <= 20; k++) begin
            clr_err = (k == 18);
            tick();
            chk("tout_err", 32'(err_timeout), 32'(k > int'(TOUT)));
        end
        clr_err     = 1'b0;
        cpu_busak_n = 1'b0;
        tick();
        chk("tout_grant", 32'(dif.dma_ack), 32'd1);
        chk("tout_sticky", 32'(err_timeout), 32'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("tout_clr", 32'(err_timeout), 32'd0);

        // CPU isolation while granted, CPU write lands afterwards
        v           = ~exp_byte(17'h01234);
        cpu_adr     = 17'h01234;
        cpu_wr      = 1'b1;
        cpu_dout    = v;
        dif.dma_adr = 17'h00777;
        #1;
        chk("iso_we", 32'(mem_we), 32'd0);
        chk("iso_adr", 32'(mem_adr), 32'h00777);
        tick();
        dif.dma_adr = 17'h01234;
        tick();
        chk("iso_ram", 32'(dif.dma_data), 32'(exp_byte(17'h01234)));
        dif.dma_req = 1'b0;
        cpu_wr      = 1'b0;
        cpu_busak_n = 1'b1;
        tick();
        repeat (GAP) tick();
        cpu_wr = 1'b1;
        #1;
        chk("cpu_we", 32'(mem_we), 32'd1);
        chk("cpu_wdata", 32'(mem_wdata), 32'(v));
        chk("cpu_adr", 32'(mem_adr), 32'h01234);
        tick();
        sh_write(17'h01234, v);
        cpu_wr = 1'b0;
        tick();
        chk("cpu_din", 32'(cpu_din), 32'(exp_byte(17'h01234)));

        // Randomized grants over a small shared address pool
        for (int t = 0; t < 30; t++) begin
            w   = int'($urandom_range(0, 6));
            len = int'($urandom_range(1, 10));
            dif.dma_req = 1'b1;
            tick();
            chk("rnd_busrq_n", 32'(cpu_busrq_n), 32'd0);
            repeat (w) begin
                tick();
                chk("rnd_wait_ack", 32'(dif.dma_ack), 32'd0);
            end
            cpu_busak_n = 1'b0;
            tick();
            chk("rnd_ack", 32'(dif.dma_ack), 32'd1);
            for (int j = 0; j < len; j++) begin
                a           = 17'(17'h00100 + $urandom_range(0, 15));
                dif.dma_adr = a;
                wr          = 1'($urandom);
                cpu_wr      = wr;
                cpu_adr     = 17'(17'h00100 + $urandom_range(0, 15));
                cpu_dout    = 8'($urandom);
                #1;
                chk("rnd_blk_we", 32'(mem_we), 32'd0);
                tick();
                chk("rnd_data", 32'(dif.dma_data), 32'(exp_byte(a)));
            end
            cpu_wr      = 1'b0;
            dif.dma_req = 1'b0;
            cpu_busak_n = 1'b1;
            tick();
            chk("rnd_drop", 32'(dif.dma_ack), 32'd0);
            repeat (GAP) begin
                a        = 17'(17'h00100 + $urandom_range(0, 15));
                v        = 8'($urandom);
                cpu_adr  = a;
                cpu_dout = v;
                cpu_wr   = 1'b1;
                #1;
                chk("rnd_cpu_we", 32'(mem_we), 32'd1);
                tick();
                sh_write(a, v);
            end
            cpu_wr = 1'b0;
            chk("rnd_err", 32'(err_timeout), 32'd0);
        end

`ifdef DMA_STAT_EN
        // Per-frame GRANT cycle count, then saturation
        frame_strobe = 1'b1;
        tick();
        frame_strobe = 1'b0;
        tick();
        for (int f = 0; f < 2; f++) begin
            repeat (25) do_grant(121);
            frame_strobe = 1'b1;
            tick();
            frame_strobe = 1'b0;
            tick();
            chk("stat_frame", 32'(dma_cycles), 32'(25 * 121));
        end
        do_grant(65540);
        frame_strobe = 1'b1;
        tick();
        frame_strobe = 1'b0;
        tick();
        chk("stat_sat", 32'(dma_cycles),
            32'((65540 > 65535) ? 65535 : 65540));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
